bank_read_sequencer: RTL
========================

# bank_read_sequencer

Byte-read sequencer for one 32-bit SRAM bank, sitting directly upstream of the bank byte-select mux. It accepts a byte-addressed burst request over a valid/ready handshake and drives the SRAM chip-select and word address. It also generates the mux's `read_enable` / `byte_sel`, delayed to line up with the SRAM read latency, so the mux registers one byte per cycle. It signals completion with a single-cycle `done` pulse.

## Interface
- `ADDR_W`, 10: byte address width; SRAM word address is `ADDR_W-2` bits.
- `SRAM_LAT`, 1: cycles from the SRAM strobe cycle to the cycle its word is valid on the mux input; legal range 1..3.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: burst request valid.
- `req_ready` out 1: sequencer can accept a request.
- `req_addr` in ADDR_W: start byte address.
- `req_len` in 4: burst length minus one; N = `req_len`+1, range 1..16 bytes.
- `sram_csb` out 1: SRAM chip select, active low, read-only port.
- `sram_addr` out ADDR_W-2: SRAM word address.
- `read_enable` out 1: to mux; the SRAM word on the mux input is valid this cycle.
- `byte_sel` out 2: to mux; byte lane, aligned with `read_enable`.
- `byte_last` out 1: high with `read_enable` for the final byte of the burst.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: single-cycle pulse at burst completion.

## Operation
- Reset values:
  - `req_ready`=1
  - `sram_csb`=1
  - `sram_addr`=0
  - `read_enable`=0
  - `byte_sel`=0
  - `byte_last`=0
  - `busy`=0
  - `done`=0
  - All alignment-pipeline stages cleared.
- State IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, capture `req_addr` into the byte pointer and N into the remaining count, then go to ISSUE.
- State ISSUE, one byte per cycle:
  - Drive `sram_addr` = pointer[ADDR_W-1:2] and push {1, pointer[1:0], remaining==1} into the SRAM_LAT-deep alignment pipeline.
  - Increment the pointer and decrement the count.
  - After the N-th byte is issued, go to DRAIN.
- State DRAIN:
  - Wait until the pipeline has emptied, i.e. the last `read_enable` has been output.
  - In the following cycle, pulse `done`=1 and return to IDLE. `req_ready`=1 in that same cycle.
- The alignment pipeline outputs drive `read_enable`, `byte_sel` and `byte_last` directly from its last stage.
- The byte pointer wraps modulo 2^ADDR_W: address 0x3FF+1 becomes 0x000, and the word address wraps with it.
- `req_ready`=0 in ISSUE and DRAIN. `req_valid` is ignored there; requests are never queued.
- `rst` asserted mid-burst:
  - Next cycle, all outputs return to their reset values and the pipeline is flushed.
  - No `done` pulse is produced for the aborted burst.

## Timing
- Request accepted at edge T.
- SRAM strobe cycles are T+1 .. T+N.
- `read_enable` is high in cycles T+1+SRAM_LAT .. T+N+SRAM_LAT, contiguous with no bubbles.
- `done` pulses in cycle T+N+SRAM_LAT+1.
- The earliest next acceptance is at the end of that cycle.
- Mux byte k is registered at the end of cycle T+k+SRAM_LAT, for k = 1..N.
- Every output is registered; there are no combinational paths from inputs to outputs.

## Configuration
- `WORD_REUSE_EN` defined:
  - `sram_csb` is driven low only on the first byte of a burst and whenever the word address changes from the previous issued byte.
  - Within the same word, `sram_csb`=1 and the SRAM holds its previous output.
  - `read_enable` and `byte_sel` timing is unchanged.
- `WORD_REUSE_EN` undefined: `sram_csb`=0 in every ISSUE cycle, so one SRAM read is issued per byte.

## Test plan
- Reset, then idle 5 cycles: `req_ready`=1, `sram_csb`=1, `read_enable`=0, `done`=0 throughout.
- SRAM_LAT=1, `req_addr`=0x004, `req_len`=3:
  - `sram_addr`=0x001 for cycles T+1..T+4.
  - `byte_sel`=0,1,2,3 with `read_enable` in T+2..T+5.
  - `byte_last` in T+5, `done` in T+6.
  - The mux outputs bytes 0..3 of the word.
- `req_addr`=0x3FE, `req_len`=3:
  - `sram_addr`=0xFF,0xFF,0x00,0x00.
  - `byte_sel`=2,3,0,1 (wrap).
- WORD_REUSE_EN, `req_addr`=0x006, `req_len`=3:
  - `sram_csb` low only in T+1 and T+3.
  - Without the macro, `sram_csb` is low T+1..T+4.
- `rst` pulsed at T+2 of a 16-byte burst:
  - From T+3, `read_enable`=0, `busy`=0, `req_ready`=1.
  - No `done` pulse.
- `req_valid` held high during a burst: no second acceptance until after `done`.
  - Back-to-back bursts show exactly one idle `read_enable` gap of SRAM_LAT+1 cycles.

Source files
------------

// File: rtl/bank_read_sequencer.sv
// Byte-read sequencer for one 32-bit SRAM bank feeding the byte-select mux.
// Optional WORD_REUSE_EN: strobe the SRAM only when the word address changes.
module bank_read_sequencer #(
    parameter int ADDR_W   = 10,
    parameter int SRAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_len,
    output logic              sram_csb,
    output logic [ADDR_W-3:0] sram_addr,
    output logic              read_enable,
    output logic [1:0]        byte_sel,
    output logic              byte_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic       v;
        logic [1:0] sel;
        logic       last;
    } lane_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [ADDR_W-3:0] ptr_word;
    logic [ADDR_W-3:0] addr_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              csb_nxt;
    logic              done_nxt;
    lane_t             iss, iss_nxt;
    lane_t             pipe [1:SRAM_LAT];

    assign ptr_word = ptr[ADDR_W-1:2];

    // iss mirrors the strobe cycle; pipe delays it by the SRAM latency
    assign read_enable = pipe[SRAM_LAT].v;
    assign byte_sel    = pipe[SRAM_LAT].sel;
    assign byte_last   = pipe[SRAM_LAT].last;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        addr_nxt  = sram_addr;
        csb_nxt   = 1'b1;
        iss_nxt   = '0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = ISSUE;
                    ptr_nxt   = req_addr + PTR_ONE;
                    cnt_nxt   = req_len;
                    addr_nxt  = req_addr[ADDR_W-1:2];
                    csb_nxt   = 1'b0;
                    iss_nxt   = '{v: 1'b1, sel: req_addr[1:0],
                                  last: (req_len == 4'd0)};
                end
            end
            ISSUE: begin
                // cnt counts bytes still to strobe after the current one
                if (cnt != 4'd0) begin
                    ptr_nxt  = ptr + PTR_ONE;
                    cnt_nxt  = cnt - 4'd1;
                    addr_nxt = ptr_word;
`ifdef WORD_REUSE_EN
                    csb_nxt  = (ptr_word == sram_addr);
`else
                    csb_nxt  = 1'b0;
`endif
                    iss_nxt  = '{v: 1'b1, sel: ptr[1:0],
                                 last: (cnt == 4'd1)};
                end else begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (read_enable && byte_last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            sram_addr <= '0;
            sram_csb  <= 1'b1;
            iss       <= '0;
            done      <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            for (int i = 1; i <= SRAM_LAT; i++) pipe[i] <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            sram_addr <= addr_nxt;
            sram_csb  <= csb_nxt;
            iss       <= iss_nxt;
            done      <= done_nxt;
            req_ready <= (state_nxt == IDLE);
            busy      <= (state_nxt != IDLE);
            pipe[1]   <= iss;
            for (int i = 2; i <= SRAM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

endmodule
